// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control definitions.
//   - FSM state encoding for the IF/ID hazard responder
//   - NOP bubble constant (addi x0,x0,0)
//   - RV32I opcode constants used by hazard detection/response logic
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } hz_state_t;

  localparam logic [31:0] NOP_CONST = 32'h0000_0013;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  // Bubble counter width; covers the legal FLUSH_CYCLES range 1..7.
  localparam int KCNT_W = 3;

endpackage

// File: rtl/ifid_hazard_resp_sat_counter.sv
// sat_counter: width-parameterised up-counter that sticks at all-ones.
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset (clears count)
//   inc    in   add one this cycle (ignored once saturated)
//   count  out  current value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n)                count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
  end

endmodule

// File: rtl/ifid_hazard_resp.sv
// ifid_hazard_resp: applies Stall/Flush requests from hazard detection to the
// IF/ID pipeline register and the PC write path.
//   RUN  : IF/ID advances each cycle
//   HOLD : load-use stall, IF and ID frozen
//   KILL : extra NOP bubbles after a taken control transfer
// Priority: reset > Flush > Stall > advance. PC controls are combinational,
// all ID-side outputs are registered.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   PcIF/InstrIF/ValidIF  fetch-stage PC, instruction, valid
//   Stall, Flush        hazard requests; FlushTarget = redirect PC
//   PcWrEn, PcRedirect, PcTarget   PC register controls (combinational)
//   InstrID, PcID, ValidID         decode-stage slot (registered)
//   Busy                state != RUN (registered)
// Optional: define HAZARD_PERF_CNT_EN to add StallCnt/FlushCnt (16-bit,
// saturating) performance counters.
module ifid_hazard_resp
  import pipe_ctrl_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              FLUSH_CYCLES = 1,
  parameter logic [XLEN-1:0] NOP_INSTR    = XLEN'(NOP_CONST)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] PcIF,
  input  logic [XLEN-1:0] InstrIF,
  input  logic            ValidIF,
  input  logic            Stall,
  input  logic            Flush,
  input  logic [XLEN-1:0] FlushTarget,
  output logic            PcWrEn,
  output logic            PcRedirect,
  output logic [XLEN-1:0] PcTarget,
  output logic [XLEN-1:0] InstrID,
  output logic [XLEN-1:0] PcID,
  output logic            ValidID,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0]     StallCnt,
  output logic [15:0]     FlushCnt,
`endif
  output logic            Busy
);

  localparam logic [KCNT_W-1:0] KCNT_INIT = KCNT_W'(FLUSH_CYCLES - 1);

  hz_state_t         state, state_nxt;
  logic [KCNT_W-1:0] kcnt, kcnt_nxt;
  logic              load_if;  // capture fetch into ID
  logic              bubble;   // write NOP into ID

  assign PcRedirect = Flush;
  assign PcTarget   = FlushTarget;

  always_comb begin
    state_nxt = state;
    kcnt_nxt  = kcnt;
    load_if   = 1'b0;
    bubble    = 1'b0;
    PcWrEn    = 1'b1;
    if (Flush) begin
      // Flush overrides stall in every state and restarts the bubble train.
      bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_nxt = ST_KILL;
        kcnt_nxt  = KCNT_INIT;
      end else begin
        state_nxt = ST_RUN;
      end
    end else begin
      unique case (state)
        ST_RUN: begin
          if (Stall) begin
            PcWrEn    = 1'b0;
            state_nxt = ST_HOLD;
          end else begin
            load_if = 1'b1;
          end
        end
        ST_HOLD: begin
          if (Stall) begin
            PcWrEn = 1'b0;
          end else begin
            load_if   = 1'b1;
            state_nxt = ST_RUN;
          end
        end
        ST_KILL: begin
          // Bubbles carry no operands, so a stall request here is moot.
          bubble   = 1'b1;
          kcnt_nxt = kcnt - 1'b1;
          if (kcnt <= KCNT_W'(1)) state_nxt = ST_RUN;
        end
        default: begin
          bubble    = 1'b1;
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      kcnt    <= '0;
      Busy    <= 1'b0;
      InstrID <= NOP_INSTR;
      PcID    <= '0;
      ValidID <= 1'b0;
    end else begin
      state <= state_nxt;
      kcnt  <= kcnt_nxt;
      Busy  <= (state_nxt != ST_RUN);
      if (bubble) begin
        InstrID <= NOP_INSTR;
        PcID    <= '0;
        ValidID <= 1'b0;
      end else if (load_if) begin
        InstrID <= ValidIF ? InstrIF : NOP_INSTR;
        PcID    <= PcIF;
        ValidID <= ValidIF;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  sat_counter #(.W(16)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (!PcWrEn),
    .count (StallCnt)
  );

  sat_counter #(.W(16)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (Flush),
    .count (FlushCnt)
  );
`endif

endmodule

// File: tb/tb_ifid_hazard_resp.sv
// Testbench for ifid_hazard_resp (FLUSH_CYCLES=2): directed test-plan
// sequence followed by random Stall/Flush/reset traffic, checked against a
// cycle-level model of the decode slot. With HAZARD_PERF_CNT_EN defined the
// perf counters and their saturation are checked too.
module tb_ifid_hazard_resp;

  localparam int          XLEN = 32;
  localparam int          FC   = 2;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [XLEN-1:0] PcIF, InstrIF, FlushTarget;
  logic            ValidIF, Stall, Flush;
  logic            PcWrEn, PcRedirect;
  logic [XLEN-1:0] PcTarget, InstrID, PcID;
  logic            ValidID, Busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0]     StallCnt, FlushCnt;
`endif

  always #5 clk = ~clk;

  ifid_hazard_resp #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PcIF        (PcIF),
    .InstrIF     (InstrIF),
    .ValidIF     (ValidIF),
    .Stall       (Stall),
    .Flush       (Flush),
    .FlushTarget (FlushTarget),
    .PcWrEn      (PcWrEn),
    .PcRedirect  (PcRedirect),
    .PcTarget    (PcTarget),
    .InstrID     (InstrID),
    .PcID        (PcID),
    .ValidID     (ValidID),
`ifdef HAZARD_PERF_CNT_EN
    .StallCnt    (StallCnt),
    .FlushCnt    (FlushCnt),
`endif
    .Busy        (Busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", tag, act, exp, $time);
    end
  endtask

  // Model of the decode slot: contents plus how many bubbles are still owed
  // and whether fetch is being held by a stall.
  logic [31:0] m_instr = NOP, m_pc = 0;
  logic        m_valid = 0, m_busy = 0;
  int          m_kill_left = 0;
  bit          m_stalled = 0;
  int          m_stall_cnt = 0, m_flush_cnt = 0;

  // One cycle: check registered state, apply inputs, check the combinational
  // PC controls, then advance the model across the coming rising edge.
  task automatic step(input bit r, input bit st, input bit fl, input bit v,
                      input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] tgt);
    bit exp_wr;
    @(negedge clk);
    chk("InstrID", InstrID, m_instr);
    chk("ValidID", {31'd0, ValidID}, {31'd0, m_valid});
    chk("Busy", {31'd0, Busy}, {31'd0, m_busy});
    if (m_valid) chk("PcID", PcID, m_pc);
`ifdef HAZARD_PERF_CNT_EN
    chk("StallCnt", {16'd0, StallCnt}, m_stall_cnt);
    chk("FlushCnt", {16'd0, FlushCnt}, m_flush_cnt);
`endif
    rst_n = r; Stall = st; Flush = fl; ValidIF = v;
    PcIF = pc; InstrIF = ins; FlushTarget = tgt;
    #1;
    exp_wr = !(st && !fl && m_kill_left == 0);
    chk("PcWrEn", {31'd0, PcWrEn}, {31'd0, exp_wr});
    chk("PcRedirect", {31'd0, PcRedirect}, {31'd0, fl});
    chk("PcTarget", PcTarget, tgt);
    if (!r) begin
      m_instr = NOP; m_pc = 0; m_valid = 0;
      m_kill_left = 0; m_stalled = 0;
      m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      if (!exp_wr && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
      if (fl && m_flush_cnt < 16'hFFFF) m_flush_cnt++;
      if (fl) begin
        m_instr = NOP; m_pc = 0; m_valid = 0;
        m_kill_left = FC - 1; m_stalled = 0;
      end else if (m_kill_left > 0) begin
        m_instr = NOP; m_pc = 0; m_valid = 0;
        m_kill_left--;
      end else if (st) begin
        m_stalled = 1;
      end else begin
        m_instr = v ? ins : NOP; m_pc = pc; m_valid = v;
        m_stalled = 0;
      end
    end
    m_busy = m_kill_left > 0 || m_stalled;
  endtask

  initial begin
    rst_n = 0; Stall = 0; Flush = 0; ValidIF = 1;
    PcIF = 0; InstrIF = 32'h00A00093; FlushTarget = 0;

    // Reset, two cycles, with valid fetch present.
    step(0, 0, 0, 1, 32'h0, 32'h00A00093, 32'h0);
    step(0, 0, 0, 1, 32'h0, 32'h00A00093, 32'h0);
    // Normal advance.
    step(1, 0, 0, 1, 32'h100, 32'h00A00093, 32'h0);
    step(1, 0, 0, 1, 32'h104, 32'h00100113, 32'h0);
    // Stall three cycles holding PcID=0x104, then release.
    step(1, 1, 0, 1, 32'h108, 32'h00200193, 32'h0);
    step(1, 1, 0, 1, 32'h108, 32'h00200193, 32'h0);
    step(1, 1, 0, 1, 32'h108, 32'h00200193, 32'h0);
    step(1, 0, 0, 1, 32'h108, 32'h00200193, 32'h0);
    // Flush to 0x200: two bubbles, then back to RUN.
    step(1, 0, 1, 1, 32'h10C, 32'h00300213, 32'h200);
    step(1, 0, 0, 1, 32'h200, 32'h00400293, 32'h0);
    step(1, 0, 0, 1, 32'h204, 32'h00500313, 32'h0);
    // Enter HOLD, then Stall+Flush together: flush wins.
    step(1, 1, 0, 1, 32'h208, 32'h00600393, 32'h0);
    step(1, 1, 1, 1, 32'h208, 32'h00600393, 32'h250);
    // Second flush during KILL restarts the bubble train, target 0x300.
    step(1, 1, 1, 1, 32'h250, 32'h00700413, 32'h300);
    step(1, 1, 0, 1, 32'h300, 32'h00800493, 32'h0);
    step(1, 0, 0, 1, 32'h304, 32'h00900513, 32'h0);
    step(1, 0, 0, 0, 32'h308, 32'h00A00593, 32'h0);
    step(1, 0, 0, 1, 32'h30C, 32'h00B00613, 32'h0);
    // Reset mid-KILL.
    step(1, 0, 1, 1, 32'h310, 32'h00C00693, 32'h400);
    step(0, 0, 0, 1, 32'h400, 32'h00D00713, 32'h0);
    step(1, 0, 0, 1, 32'h404, 32'h00E00793, 32'h0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(99) >= 2,
           $urandom_range(99) < 30,
           $urandom_range(99) < 12,
           $urandom_range(99) < 80,
           $urandom & 32'hFFFF_FFFC, $urandom, $urandom & 32'hFFFF_FFFC);
    end

`ifdef HAZARD_PERF_CNT_EN
    // Clean counters, then 4 stall cycles and 2 flushes.
    step(0, 0, 0, 1, 32'h0, 32'h00A00093, 32'h0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 32'h10, 32'h00A00093, 32'h0);
    step(1, 0, 1, 1, 32'h10, 32'h00A00093, 32'h80);
    step(1, 0, 0, 1, 32'h80, 32'h00A00093, 32'h0);
    step(1, 0, 1, 1, 32'h84, 32'h00A00093, 32'h90);
    step(1, 0, 0, 1, 32'h90, 32'h00A00093, 32'h0);
    step(1, 0, 0, 1, 32'h94, 32'h00A00093, 32'h0);
    // Long stall drives StallCnt into saturation.
    for (int i = 0; i < 65540; i++) step(1, 1, 0, 1, 32'h98, 32'h00A00093, 32'h0);
    step(1, 0, 0, 1, 32'h98, 32'h00A00093, 32'h0);
`endif

    // Final registered-state check after the last edge.
    step(1, 0, 0, 1, 32'h500, 32'h00F00813, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
